counter_mod_k_chain: RTL and testbench

//   Cascade of C modulo-k counter stages with per-stage modulus, up/down mode,

---
 rtl/counter_mod_k_chain.sv | 72 +++++++
 tb/tb_counter_mod_k_chain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod_k_chain.sv
// Cascade of C modulo-k counter stages; stage 0 steps on i_en and each later stage
// steps when its predecessor wraps in the same cycle. Rollover flags are registered pulses.
module counter_mod_k_chain #(
    parameter int unsigned N = 8,
    parameter int unsigned C = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_up,
    input  logic [C*N-1:0]   i_k,
    output logic [C*N-1:0]   o_count,
    output logic [C-1:0]     o_roll_over
);

    localparam logic [N-1:0] One = N'(1);

    logic [C-1:0][N-1:0] cnt_q, cnt_d;
    logic [C-1:0]        roll_q, wrap_d;
    logic                carry;
    logic [N-1:0]        k_j, top_j;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = '0;
        carry  = i_en;
        k_j    = '0;
        top_j  = '0;
        for (int j = 0; j < C; j++) begin
            k_j = i_k[j*N +: N];
            // top_j is m-1 with m = max(k,1); k = 0 maps to 0 without underflow
            top_j = (k_j == '0) ? '0 : k_j - One;
            if (carry) begin
                if (i_up) begin
                    if (cnt_q[j] >= top_j) begin
                        cnt_d[j]  = '0;
                        wrap_d[j] = 1'b1;
                    end else begin
                        cnt_d[j] = cnt_q[j] + One;
                    end
                end else begin
                    // c > m-1 is c >= m; stale out-of-range counts are corrected here
                    if (cnt_q[j] == '0 || cnt_q[j] > top_j) begin
                        cnt_d[j]  = top_j;
                        wrap_d[j] = 1'b1;
                    end else begin
                        cnt_d[j] = cnt_q[j] - One;
                    end
                end
            end
            carry = wrap_d[j];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q  <= '0;
            roll_q <= '0;
        end else if (i_clear) begin
            cnt_q  <= '0;
            roll_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            roll_q <= wrap_d;
        end
    end

    assign o_count     = cnt_q;
    assign o_roll_over = roll_q;

endmodule

// File: tb/tb_counter_mod_k_chain.sv
// Self-checking bench for counter_mod_k_chain: directed vector table, hand-written
// reset sequence, and randomized stimulus against an integer reference model.
module tb_counter_mod_k_chain;

    localparam int N = 8;
    localparam int C = 3;
    localparam int W = N * C;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic         clr   = 1'b0;
    logic         up    = 1'b1;
    logic [W-1:0] k     = '0;
    logic [W-1:0] count;
    logic [C-1:0] roll;

    always #5 clk = ~clk;

    counter_mod_k_chain #(.N(N), .C(C)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_en        (en),
        .i_clear     (clr),
        .i_up        (up),
        .i_k         (k),
        .o_count     (count),
        .o_roll_over (roll)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer counts following the step rules
    int mc[C];
    bit mr[C];

    task automatic model_reset();
        for (int j = 0; j < C; j++) begin
            mc[j] = 0;
            mr[j] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit e, input bit cl, input bit u, input logic [W-1:0] kv);
        bit s;
        int m;
        if (cl) begin
            model_reset();
        end else begin
            s = e;
            for (int j = 0; j < C; j++) begin
                m = int'(kv[j*N +: N]);
                if (m < 1) m = 1;
                mr[j] = 1'b0;
                if (s) begin
                    if (u) begin
                        if (mc[j] + 1 >= m) begin mc[j] = 0; mr[j] = 1'b1; end
                        else mc[j] = mc[j] + 1;
                    end else begin
                        if (mc[j] == 0 || mc[j] >= m) begin mc[j] = m - 1; mr[j] = 1'b1; end
                        else mc[j] = mc[j] - 1;
                    end
                end
                s = mr[j];
            end
        end
    endtask

    function automatic logic [W-1:0] model_count();
        logic [W-1:0] v;
        for (int j = 0; j < C; j++) v[j*N +: N] = N'(mc[j]);
        return v;
    endfunction

    function automatic logic [C-1:0] model_roll();
        logic [C-1:0] v;
        for (int j = 0; j < C; j++) v[j] = mr[j];
        return v;
    endfunction

    // Drives inputs off-edge, lets one rising edge pass, returns 1 time unit after it
    task automatic drive_edge(input bit e, input bit cl, input bit u, input logic [W-1:0] kv);
        en  = e;
        clr = cl;
        up  = u;
        k   = kv;
        @(posedge clk);
        model_edge(e, cl, u, kv);
        #1;
    endtask

    // Asserts reset between edges and checks outputs clear with no clock edge
    task automatic async_reset();
        en    = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        #2;
        check("async_reset_count", count, '0);
        check("async_reset_roll", roll, '0);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit           rst;
        bit           en;
        bit           clr;
        bit           up;
        logic [W-1:0] k;
        logic [W-1:0] cnt;
        logic [C-1:0] roll;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit e, input bit cl, input bit u,
                                input logic [W-1:0] kv, input logic [W-1:0] c,
                                input logic [C-1:0] ro);
        vec_t v;
        v.rst = r; v.en = e; v.clr = cl; v.up = u; v.k = kv; v.cnt = c; v.roll = ro;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [W-1:0] kv;
        logic [W-1:0] k543;
        logic [W-1:0] k545;
        k543 = 24'h050403;
        k545 = 24'h050405;

        // Cascade up-count, k = {5,4,3}
        tbl.push_back(mk(1, 1, 0, 1, k543, 24'h000001, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000002, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000100, 3'b001));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000101, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000102, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000200, 3'b001));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000201, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000202, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000300, 3'b001));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000301, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000302, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h010000, 3'b011));
        // Down from reset: full cascade wrap
        tbl.push_back(mk(1, 1, 0, 0, k543, 24'h040302, 3'b111));
        tbl.push_back(mk(0, 1, 0, 0, k543, 24'h040301, 3'b000));
        tbl.push_back(mk(0, 0, 0, 0, k543, 24'h040301, 3'b000));
        // Stale out-of-range count after k shrinks, corrected on next up step
        tbl.push_back(mk(1, 1, 0, 1, k545, 24'h000001, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k545, 24'h000002, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k545, 24'h000003, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k545, 24'h000004, 3'b000));
        tbl.push_back(mk(0, 0, 0, 1, k543, 24'h000004, 3'b000));
        tbl.push_back(mk(0, 0, 0, 1, k543, 24'h000004, 3'b000));
        tbl.push_back(mk(0, 0, 0, 1, k543, 24'h000004, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000100, 3'b001));
        tbl.push_back(mk(0, 0, 0, 1, k543, 24'h000100, 3'b000));
        // Same stale count corrected by a down step
        tbl.push_back(mk(1, 1, 0, 1, k545, 24'h000001, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k545, 24'h000002, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k545, 24'h000003, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k545, 24'h000004, 3'b000));
        tbl.push_back(mk(0, 1, 0, 0, k543, 24'h040302, 3'b111));
        // k = 0 and k = 1 stages hold 0 and wrap on every step
        tbl.push_back(mk(1, 1, 0, 1, 24'h050100, 24'h010000, 3'b011));
        tbl.push_back(mk(0, 1, 0, 1, 24'h050100, 24'h020000, 3'b011));
        tbl.push_back(mk(0, 1, 0, 1, 24'h050100, 24'h030000, 3'b011));
        tbl.push_back(mk(0, 0, 0, 1, 24'h050100, 24'h030000, 3'b000));
        // Clear beats a pending wrap
        tbl.push_back(mk(1, 1, 0, 1, k543, 24'h000001, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000002, 3'b000));
        tbl.push_back(mk(0, 1, 1, 1, k543, 24'h000000, 3'b000));
        tbl.push_back(mk(0, 1, 0, 1, k543, 24'h000001, 3'b000));

        #1;
        check("reset_count", count, '0);
        check("reset_roll", roll, '0);
        model_reset();
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].rst) async_reset();
            drive_edge(tbl[i].en, tbl[i].clr, tbl[i].up, tbl[i].k);
            check($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
            check($sformatf("tbl%0d_roll", i), roll, tbl[i].roll);
        end

        // Reset dropped mid-count while a rollover pulse is showing
        async_reset();
        for (int i = 0; i < 3; i++) drive_edge(1, 0, 1, k543);
        check("pre_reset_roll", roll, 3'b001);
        async_reset();
        for (int i = 1; i <= 3; i++) begin
            drive_edge(1, 0, 1, k543);
            check($sformatf("resume%0d_count", i), count, model_count());
            check($sformatf("resume%0d_roll0", i), roll[0], (i == 3) ? 1'b1 : 1'b0);
        end

        // Randomized run against the model
        async_reset();
        kv = k543;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                for (int j = 0; j < C; j++) begin
                    case ($urandom_range(0, 4))
                        0:       kv[j*N +: N] = '0;
                        1:       kv[j*N +: N] = 8'd1;
                        2, 3:    kv[j*N +: N] = 8'($urandom_range(2, 6));
                        default: kv[j*N +: N] = 8'($urandom_range(0, 255));
                    endcase
                end
            end
            if ($urandom_range(0, 199) == 0) async_reset();
            drive_edge($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                       1'($urandom_range(0, 1)), kv);
            check("rand_count", count, model_count());
            check("rand_roll", roll, model_roll());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
